// File: rtl/aes_block_sequencer_if.sv
// Host stream and AES-core bus of aes_block_sequencer; seq_ctr_load/seq_ctr_iv
// exist only when AES_SEQ_CTR_MODE_EN is defined.
interface aes_block_sequencer_if #(
   parameter int TAG_W = 8
);
   logic [127:0]     seq_key_in;
   logic             seq_in_valid;
   logic             seq_in_ready;
   logic [127:0]     seq_in_data;
   logic             seq_out_valid;
   logic             seq_out_ready;
   logic [127:0]     seq_out_data;
   logic [TAG_W-1:0] seq_out_tag;
   logic             seq_timeout_err;
`ifdef AES_SEQ_CTR_MODE_EN
   logic             seq_ctr_load;
   logic [127:0]     seq_ctr_iv;
`endif
   logic             core_en;
   logic [127:0]     core_data_in;
   logic [127:0]     core_key_in;
   logic [127:0]     core_data_out;
   logic             core_data_out_valid;

   modport slave (
      input  seq_key_in, seq_in_valid, seq_in_data, seq_out_ready,
             core_data_out, core_data_out_valid,
`ifdef AES_SEQ_CTR_MODE_EN
      input  seq_ctr_load, seq_ctr_iv,
`endif
      output seq_in_ready, seq_out_valid, seq_out_data, seq_out_tag,
             seq_timeout_err, core_en, core_data_in, core_key_in
   );

   modport master (
      output seq_key_in, seq_in_valid, seq_in_data, seq_out_ready,
             core_data_out, core_data_out_valid,
`ifdef AES_SEQ_CTR_MODE_EN
      output seq_ctr_load, seq_ctr_iv,
`endif
      input  seq_in_ready, seq_out_valid, seq_out_data, seq_out_tag,
             seq_timeout_err, core_en, core_data_in, core_key_in
   );
endinterface

// File: rtl/aes_block_sequencer.sv
// Buffers tagged {key, block} entries and feeds them one at a time to an external
// AES core with a timeout guard. AES_SEQ_CTR_MODE_EN selects CTR mode (default ECB).
module aes_block_sequencer #(
   parameter int DEPTH   = 4,
   parameter int TAG_W   = 8,
   parameter int TIMEOUT = 64
) (
   input  logic                 AES_clk,
   input  logic                 AES_rst_n,
   aes_block_sequencer_if.slave bus
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(TIMEOUT + 1);
   localparam logic [AW:0]   FULL = (AW + 1)'(DEPTH);
   localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, OUT} state_t;

   logic [127:0]     fifo_key  [DEPTH];
   logic [127:0]     fifo_data [DEPTH];
   logic [TAG_W-1:0] fifo_tag  [DEPTH];
   logic [AW-1:0]    wr_ptr, rd_ptr;
   logic [AW:0]      count;
   logic [TAG_W-1:0] tag_cnt;
   logic             push, pop;

   state_t           state;
   logic [CW-1:0]    wait_cnt;
   logic [TAG_W-1:0] issue_tag;
   logic             core_en;
   logic [127:0]     core_data_in, core_key_in;
   logic             out_valid;
   logic [127:0]     out_data;
   logic [TAG_W-1:0] out_tag;
   logic             timeout_err;
   logic [127:0]     result;

   assign bus.seq_in_ready    = (count != FULL);
   assign bus.seq_out_valid   = out_valid;
   assign bus.seq_out_data    = out_data;
   assign bus.seq_out_tag     = out_tag;
   assign bus.seq_timeout_err = timeout_err;
   assign bus.core_en         = core_en;
   assign bus.core_data_in    = core_data_in;
   assign bus.core_key_in     = core_key_in;

   assign push = bus.seq_in_valid && bus.seq_in_ready;
   assign pop  = (state == IDLE) && (count != '0);

   always_ff @(posedge AES_clk) begin
      if (push) begin
         fifo_key[wr_ptr]  <= bus.seq_key_in;
         fifo_data[wr_ptr] <= bus.seq_in_data;
         fifo_tag[wr_ptr]  <= tag_cnt;
      end
   end

   always_ff @(posedge AES_clk or negedge AES_rst_n) begin
      if (!AES_rst_n) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count   <= '0;
         tag_cnt <= '0;
      end else begin
         if (push) begin
            wr_ptr  <= wr_ptr + AW'(1);
            tag_cnt <= tag_cnt + TAG_W'(1);
         end
         if (pop)
            rd_ptr <= rd_ptr + AW'(1);
         case ({push, pop})
            2'b10:   count <= count + (AW + 1)'(1);
            2'b01:   count <= count - (AW + 1)'(1);
            default: count <= count;
         endcase
      end
   end

`ifdef AES_SEQ_CTR_MODE_EN
   logic [127:0] ctr;
   logic [127:0] plain;

   // A load in the same cycle as an ISSUE wins over the increment.
   always_ff @(posedge AES_clk or negedge AES_rst_n) begin
      if (!AES_rst_n)
         ctr <= '0;
      else if (bus.seq_ctr_load)
         ctr <= bus.seq_ctr_iv;
      else if (state == ISSUE)
         ctr <= ctr + 128'd1;
   end

   always_ff @(posedge AES_clk) begin
      if (pop) begin
         issue_tag <= fifo_tag[rd_ptr];
         plain     <= fifo_data[rd_ptr];
      end
   end

   assign result = bus.core_data_out ^ plain;
`else
   always_ff @(posedge AES_clk) begin
      if (pop)
         issue_tag <= fifo_tag[rd_ptr];
   end

   assign result = bus.core_data_out;
`endif

   // Core strobes are only honoured in WAIT; anything else on the strobe is ignored.
   always_ff @(posedge AES_clk or negedge AES_rst_n) begin
      if (!AES_rst_n) begin
         state        <= IDLE;
         wait_cnt     <= '0;
         core_en      <= 1'b0;
         core_data_in <= '0;
         core_key_in  <= '0;
         out_valid    <= 1'b0;
         out_data     <= '0;
         out_tag      <= '0;
         timeout_err  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (pop) begin
                  core_en     <= 1'b1;
                  core_key_in <= fifo_key[rd_ptr];
`ifdef AES_SEQ_CTR_MODE_EN
                  core_data_in <= ctr;
`else
                  core_data_in <= fifo_data[rd_ptr];
`endif
                  state <= ISSUE;
               end
            end
            ISSUE: begin
               wait_cnt <= '0;
               state    <= WAIT;
            end
            WAIT: begin
               if (bus.core_data_out_valid) begin
                  core_en   <= 1'b0;
                  out_valid <= 1'b1;
                  out_data  <= result;
                  out_tag   <= issue_tag;
                  state     <= OUT;
               end else if (wait_cnt == LAST) begin
                  core_en     <= 1'b0;
                  timeout_err <= 1'b1;
                  out_valid   <= 1'b1;
                  out_data    <= '0;
                  out_tag     <= issue_tag;
                  state       <= OUT;
               end else begin
                  wait_cnt <= wait_cnt + CW'(1);
               end
            end
            OUT: begin
               if (bus.seq_out_ready) begin
                  out_valid <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_aes_block_sequencer.sv
// Scoreboard bench for aes_block_sequencer: random traffic, stalls, timeout,
// reset mid-flight, and (with AES_SEQ_CTR_MODE_EN) counter wrap.
module tb_aes_block_sequencer;
   localparam int DEPTH   = 4;
   localparam int TAG_W   = 8;
   localparam int TIMEOUT = 64;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   aes_block_sequencer_if #(.TAG_W(TAG_W)) bus();

   aes_block_sequencer #(.DEPTH(DEPTH), .TAG_W(TAG_W), .TIMEOUT(TIMEOUT)) dut (
      .AES_clk   (clk),
      .AES_rst_n (rst_n),
      .bus       (bus)
   );

   int total = 0;
   int bad   = 0;

   logic [127:0]     exp_data_q[$];
   logic [TAG_W-1:0] exp_tag_q[$];
   logic [127:0]     exp_cin_q[$];
   logic [127:0]     exp_kin_q[$];

   int           tag_model = 0;
   logic [127:0] ctr_model = '0;
   int           core_lat  = 3;
   bit           core_mute = 0;
   bit           exp_mute  = 0;
   bit           hold_ready = 0;
   bit           rand_ready = 0;

   // Stand-in for the AES core: any fixed keyed transform, passed through unchanged.
   function automatic logic [127:0] core_fn(input logic [127:0] k, input logic [127:0] d);
      return {d[95:0], d[127:96]} ^ k ^ 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;
   endfunction

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic push_block(input logic [127:0] k, input logic [127:0] d);
      int  n   = 0;
      bit  acc = 0;
      bus.seq_key_in   = k;
      bus.seq_in_data  = d;
      bus.seq_in_valid = 1'b1;
      while (!acc && n < 1000) begin
         @(negedge clk);
         acc = bus.seq_in_ready;
         @(posedge clk);
         #1;
         n++;
      end
      if (!acc) begin
         total++;
         bad++;
         $display("FAIL push_accept: got no accept in %0d cycles, expected accept", n);
      end else begin
         exp_tag_q.push_back(TAG_W'(tag_model));
         tag_model++;
         exp_kin_q.push_back(k);
`ifdef AES_SEQ_CTR_MODE_EN
         exp_cin_q.push_back(ctr_model);
         exp_data_q.push_back(exp_mute ? 128'h0 : (core_fn(k, ctr_model) ^ d));
         ctr_model = ctr_model + 128'd1;
`else
         exp_cin_q.push_back(d);
         exp_data_q.push_back(exp_mute ? 128'h0 : core_fn(k, d));
`endif
      end
   endtask

   task automatic idle_in(input int n);
      bus.seq_in_valid = 1'b0;
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic drain(input string name);
      int n = 0;
      while (exp_data_q.size() != 0 && n < 5000) begin
         @(negedge clk);
         n++;
      end
      if (exp_data_q.size() != 0) begin
         total++;
         bad++;
         $display("FAIL drain_%s: got %0d blocks pending, expected 0", name, exp_data_q.size());
         exp_data_q.delete();
         exp_tag_q.delete();
      end
      repeat (3) @(posedge clk);
      #1;
   endtask

   function automatic logic [127:0] rnd128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   // Behavioural AES core: strobes a fixed number of cycles after seeing core_en.
   initial begin
      bit           active;
      bit           mute_l;
      int           cnt;
      int           lat_l;
      logic [127:0] ck, cd;
      active = 0;
      mute_l = 0;
      cnt    = 0;
      lat_l  = 1;
      bus.core_data_out_valid = 1'b0;
      bus.core_data_out       = '0;
      forever begin
         @(posedge clk);
         #1;
         bus.core_data_out_valid = 1'b0;
         if (!active) begin
            if (bus.core_en) begin
               active = 1;
               cnt    = 0;
               lat_l  = core_lat;
               mute_l = core_mute;
               ck     = bus.core_key_in;
               cd     = bus.core_data_in;
            end else if ($urandom_range(0, 7) == 0) begin
               bus.core_data_out_valid = 1'b1;
               bus.core_data_out       = rnd128();
            end
         end else begin
            cnt++;
            if (mute_l) begin
               if (!bus.core_en) active = 0;
            end else if (cnt == lat_l) begin
               bus.core_data_out_valid = 1'b1;
               bus.core_data_out       = core_fn(ck, cd);
               active = 0;
            end
         end
      end
   end

   initial begin
      bus.seq_out_ready = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         if (hold_ready)      bus.seq_out_ready = 1'b0;
         else if (rand_ready) bus.seq_out_ready = 1'($urandom_range(0, 1));
         else                 bus.seq_out_ready = 1'b1;
      end
   end

   // Monitor: checks each core issue and each output handshake against the queues.
   initial begin
      logic         prev_en;
      logic [127:0] e1, e2;
      logic [TAG_W-1:0] et;
      prev_en = 1'b0;
      forever begin
         @(negedge clk);
         if (rst_n) begin
            if (bus.core_en && !prev_en) begin
               if (exp_cin_q.size() == 0) begin
                  total++;
                  bad++;
                  $display("FAIL core_issue: got issue of %h, expected none", bus.core_data_in);
               end else begin
                  e1 = exp_cin_q.pop_front();
                  e2 = exp_kin_q.pop_front();
                  chk("core_data_in", bus.core_data_in, e1);
                  chk("core_key_in", bus.core_key_in, e2);
               end
            end
            if (bus.seq_out_valid && bus.seq_out_ready) begin
               if (exp_data_q.size() == 0) begin
                  total++;
                  bad++;
                  $display("FAIL out_unexpected: got data %h tag %h, expected none",
                           bus.seq_out_data, bus.seq_out_tag);
               end else begin
                  e1 = exp_data_q.pop_front();
                  et = exp_tag_q.pop_front();
                  chk("out_data", bus.seq_out_data, e1);
                  chk("out_tag", 128'(bus.seq_out_tag), 128'(et));
               end
            end
         end
         prev_en = bus.core_en;
      end
   end

   initial begin
      #3000000;
      $display("FAIL watchdog: got no finish, expected finish before time limit");
      $fatal(1, "watchdog");
   end

   task automatic chk_reset_outputs(input string name);
      chk({name, "_in_ready"},  128'(bus.seq_in_ready), 128'd1);
      chk({name, "_out_valid"}, 128'(bus.seq_out_valid), 128'd0);
      chk({name, "_out_data"},  bus.seq_out_data, 128'd0);
      chk({name, "_out_tag"},   128'(bus.seq_out_tag), 128'd0);
      chk({name, "_core_en"},   128'(bus.core_en), 128'd0);
      chk({name, "_core_din"},  bus.core_data_in, 128'd0);
      chk({name, "_core_kin"},  bus.core_key_in, 128'd0);
      chk({name, "_tmo_err"},   128'(bus.seq_timeout_err), 128'd0);
   endtask

   initial begin
      int           n;
      int           run;
      bit           acc4, saw;
      logic [127:0] cap_d;
      logic [TAG_W-1:0] cap_t;
      bus.seq_in_valid = 1'b0;
      bus.seq_key_in   = '0;
      bus.seq_in_data  = '0;
`ifdef AES_SEQ_CTR_MODE_EN
      bus.seq_ctr_load = 1'b0;
      bus.seq_ctr_iv   = '0;
`endif
      #12;
      chk_reset_outputs("por");
      @(posedge clk);
      #2 rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Known-vector block with a 10-cycle core.
      core_lat = 10;
      push_block(128'haa2bdb40bff6a5e8caa9ba3ebc1e2acc, 128'h000000b3000000000000000000000000);
      idle_in(0);
      drain("ecb");

      // Random traffic with random backpressure; long enough to wrap the tag.
      rand_ready = 1;
      for (int i = 0; i < 270; i++) begin
         core_lat = $urandom_range(1, 6);
         push_block(rnd128(), rnd128());
         if ($urandom_range(0, 3) == 0) idle_in($urandom_range(1, 4));
      end
      idle_in(0);
      drain("random");
      rand_ready = 0;

      // Back-to-back with a stalled output: one block leaves the FIFO, four fill it.
      hold_ready = 1;
      core_lat   = 2;
      idle_in(2);
      acc4 = 0;
      for (int i = 0; i < 5; i++) begin
         push_block(rnd128(), rnd128());
         if (i == 3) acc4 = bus.seq_in_ready;
      end
      idle_in(0);
      chk("b2b_ready_after_4", 128'(acc4), 128'd1);
      @(negedge clk);
      chk("b2b_full_ready", 128'(bus.seq_in_ready), 128'd0);
      @(posedge clk);
      #1;
      hold_ready = 0;
      drain("b2b");

      // Output stall: valid and data frozen, no core activity.
      hold_ready = 1;
      idle_in(2);
      push_block(rnd128(), rnd128());
      push_block(rnd128(), rnd128());
      idle_in(0);
      n = 0;
      while (!bus.seq_out_valid && n < 200) begin
         @(negedge clk);
         n++;
      end
      @(negedge clk);
      cap_d = bus.seq_out_data;
      cap_t = bus.seq_out_tag;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         chk("stall_valid", 128'(bus.seq_out_valid), 128'd1);
         chk("stall_data", bus.seq_out_data, cap_d);
         chk("stall_tag", 128'(bus.seq_out_tag), 128'(cap_t));
         chk("stall_core_en", 128'(bus.core_en), 128'd0);
      end
      @(posedge clk);
      #1;
      hold_ready = 0;
      drain("stall");

      // Core never answers: WAIT lasts TIMEOUT cycles, zero result, sticky flag.
      chk("tmo_err_before", 128'(bus.seq_timeout_err), 128'd0);
      core_mute = 1;
      exp_mute  = 1;
      push_block(rnd128(), rnd128());
      exp_mute  = 0;
      idle_in(0);
      n = 0;
      while (!bus.core_en && n < 50) begin
         @(negedge clk);
         n++;
      end
      run = 0;
      while (bus.core_en && run < 500) begin
         run++;
         @(negedge clk);
      end
      chk("tmo_core_en_cycles", 128'(run), 128'(TIMEOUT + 1));
      core_mute = 0;
      chk("tmo_err_set", 128'(bus.seq_timeout_err), 128'd1);
      @(posedge clk);
      #1;
      core_lat = 4;
      push_block(rnd128(), rnd128());
      idle_in(0);
      drain("tmo");
      chk("tmo_err_sticky", 128'(bus.seq_timeout_err), 128'd1);

      // Reset while the core is working; its late strobe must be dropped.
      core_lat = 30;
      push_block(rnd128(), rnd128());
      idle_in(0);
      n = 0;
      while (!bus.core_en && n < 50) begin
         @(negedge clk);
         n++;
      end
      repeat (6) @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      chk_reset_outputs("midwait");
      exp_data_q.delete();
      exp_tag_q.delete();
      exp_cin_q.delete();
      exp_kin_q.delete();
      tag_model = 0;
      ctr_model = '0;
      repeat (2) @(posedge clk);
      #2 rst_n = 1'b1;
      saw = 0;
      repeat (40) begin
         @(negedge clk);
         if (bus.seq_out_valid) saw = 1;
      end
      chk("late_strobe_no_out", 128'(saw), 128'd0);
      @(posedge clk);
      #1;
      core_lat = 3;
      push_block(rnd128(), rnd128());
      idle_in(0);
      drain("post_reset");

`ifdef AES_SEQ_CTR_MODE_EN
      // Counter loaded to all-ones wraps to zero on the second block.
      bus.seq_ctr_iv   = {128{1'b1}};
      bus.seq_ctr_load = 1'b1;
      @(posedge clk);
      #1;
      bus.seq_ctr_load = 1'b0;
      ctr_model = {128{1'b1}};
      push_block(rnd128(), rnd128());
      push_block(rnd128(), rnd128());
      idle_in(0);
      drain("ctr");
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/aes_block_sequencer.md
AES_BLOCK_SEQUENCER -- requirements
Module: aes_block_sequencer

Interface
REQ-001 Parameter DEPTH, default 4: input FIFO depth in blocks; power of two, 2..64.
REQ-002 Parameter TAG_W, default 8: width of the per-block sequence tag.
REQ-003 Parameter TIMEOUT, default 64: maximum cycles to wait for core_data_out_valid.
REQ-004 AES_clk  in  1  sole clock; all logic rising-edge.
REQ-005 AES_rst_n  in  1  asynchronous active-low reset.
REQ-006 seq_key_in  in  128  key; sampled with each accepted block.
REQ-007 seq_in_valid / seq_in_ready  in / out  1 / 1  input handshake.
REQ-008 seq_in_data  in  128  plaintext block.
REQ-009 seq_out_valid / seq_out_ready  out / in  1 / 1  output handshake.
REQ-010 seq_out_data  out  128  result block.
REQ-011 seq_out_tag  out  TAG_W  tag of the result.
REQ-012 seq_timeout_err  out  1  sticky core-timeout flag.
REQ-013 seq_ctr_load  in  1  CTR build only: load seq_ctr_iv into the counter.
REQ-014 seq_ctr_iv  in  128  CTR build only: initial counter block.
REQ-015 core_en  out  1  enable to the AES core.
REQ-016 core_data_in / core_key_in  out  128 / 128  block and key to the core.
REQ-017 core_data_out / core_data_out_valid  in  128 / 1  core result and strobe.

Function
REQ-018 A transfer occurs on any cycle where valid and ready are both 1; data is accepted on that edge.
REQ-019 The input FIFO stores {key, data, tag}; seq_in_ready = FIFO not full; the tag counter increments per accepted block and wraps at 2^TAG_W.
REQ-020 The FSM states are IDLE, ISSUE, WAIT and OUT.
REQ-021 IDLE -> ISSUE when the FIFO is non-empty; the head entry is popped into the issue register on that edge.
REQ-022 ISSUE (1 cycle) asserts core_en; core_data_in and core_key_in are driven from the issue register.
REQ-023 WAIT holds core_en = 1 with inputs stable until core_data_out_valid = 1, then captures the result and goes to OUT.
REQ-024 If WAIT lasts TIMEOUT cycles without a strobe: set seq_timeout_err, emit result 128'h0 with the block's tag, go to OUT.
REQ-025 OUT holds seq_out_valid = 1 with data and tag stable until seq_out_ready = 1, then returns to IDLE.
REQ-026 core_en is 0 in IDLE and OUT; there is never more than one block in flight.
REQ-027 core_data_out_valid outside WAIT is ignored.
REQ-028 A simultaneous FIFO push and pop when full is not possible: ready is already 0.
REQ-029 A simultaneous push and pop when non-full is allowed; the occupancy count is unchanged.
REQ-030 Minimum latency from accept to seq_out_valid = 3 cycles plus core latency.

Reset
REQ-031 Asserting AES_rst_n low at any time, including mid-WAIT, immediately produces:
- FIFO empty
- FSM in IDLE
- tag counter 0
- CTR counter 0
- seq_in_ready = 1
- seq_out_valid = 0, seq_out_data = 0, seq_out_tag = 0
- core_en = 0, core_data_in = 0, core_key_in = 0
- seq_timeout_err = 0
REQ-032 An in-flight block is discarded on reset; a late core strobe after reset is ignored.

Configuration
REQ-033 Macro AES_SEQ_CTR_MODE_EN.
- When defined: core_data_in = counter; seq_out_data = core_data_out XOR stored plaintext; the counter increments mod 2^128 at each ISSUE; seq_ctr_load = 1 loads seq_ctr_iv and takes priority over an increment in the same cycle.
- When undefined (ECB): core_data_in = plaintext; seq_out_data = core_data_out; seq_ctr_load and seq_ctr_iv are absent.

Verification
REQ-034 ECB: key aa2bdb40bff6a5e8caa9ba3ebc1e2acc, data 000000b3000000000000000000000000; model core returns after 10 cycles -> one output, tag 0, data equal to the reference AES result.
REQ-035 Back-to-back: 5 blocks pushed continuously with DEPTH=4 -> seq_in_ready falls after the 4th (or 5th if a pop has occurred); outputs appear in order with tags 0..4.
REQ-036 Backpressure: seq_out_ready held 0 for 20 cycles -> seq_out_valid and data stay stable; no core_en during the stall.
REQ-037 Timeout: core never strobes, TIMEOUT=64 -> after 64 WAIT cycles, seq_timeout_err = 1, output 128'h0 with the correct tag; the next block proceeds normally.
REQ-038 Reset mid-WAIT: AES_rst_n pulsed low -> all outputs 0 at once; a core strobe arriving afterwards produces no output.
REQ-039 CTR: iv ffffffffffffffffffffffffffffffff loaded, two blocks issued -> core_data_in = ffff...ff, then 000...000 (wrap); outputs equal keystream XOR plaintext.
